// File: rtl/line_cmd_sched.sv
// line_cmd_sched: round-robin scheduler sharing one line engine between NREQ requesters via a command FIFO.
// Optional trivial-reject clipping at grant time is enabled with `define LINE_CLIP_EN.
module line_cmd_sched #(
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SCR_W      = 640,
  parameter int SCR_H      = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*64-1:0] req_cmd_i,
  output logic [NREQ-1:0]    ack_o,
  output logic [NREQ-1:0]    done_o,
  output logic               eng_start_o,
  output logic [15:0]        eng_x1_o,
  output logic [15:0]        eng_y1_o,
  output logic [15:0]        eng_x2_o,
  output logic [15:0]        eng_y2_o,
  input  logic               eng_rdy_i,
  output logic               busy_o,
  output logic [15:0]        line_cnt_o,
  output logic [15:0]        rej_cnt_o
);
  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT_BUSY = 2'd1, S_WAIT_DONE = 2'd2;
  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, gnt_id, cur_id_q, head_id;
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q, cnt_d, sum_w;
  logic [IW:0]     sum;
  logic [IW+63:0]  mem_q [FIFO_DEPTH];
  logic [63:0]     gnt_cmd, head_cmd, crd_q, crd;
  logic [NREQ-1:0] done_q, rot;
  logic [15:0]     line_cnt_q, rej_cnt_q;
  logic            gnt_v, rej, push, issue, fin, fin_q, busy_q;
  function automatic logic [3:0] outcode(input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] xs, ys;
    xs = {{16{x[15]}}, x};
    ys = {{16{y[15]}}, y};
    return {xs < 0, xs >= SCR_W, ys < 0, ys >= SCR_H};
  endfunction
  // Rotate requests so bit 0 is the RR pointer; the lowest set bit wins.
  always_comb begin
    rot = NREQ'({req_i, req_i} >> ptr_q);
    sum = '0;
    gnt_v = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      gnt_v = 1'b1;
    end
    gnt_id = IW'(sum >= (IW+1)'(NREQ) ? sum - (IW+1)'(NREQ) : sum);
    gnt_v = gnt_v & rst_n & (cnt_q != (AW+1)'(FIFO_DEPTH));
  end
  assign gnt_cmd = req_cmd_i[64*gnt_id +: 64];
  assign ack_o = gnt_v ? NREQ'(1) << gnt_id : '0;
`ifdef LINE_CLIP_EN
  assign rej = gnt_v & |(outcode(gnt_cmd[63:48], gnt_cmd[47:32]) & outcode(gnt_cmd[31:16], gnt_cmd[15:0]));
`else
  assign rej = 1'b0;
`endif
  assign push = gnt_v & ~rej;
  assign {head_id, head_cmd} = mem_q[rp_q];
  // fin_q keeps the next issue at least one cycle behind the done pulse.
  assign issue = state_q == S_IDLE && cnt_q != '0 && eng_rdy_i && !fin_q;
  assign fin = state_q == S_WAIT_DONE && eng_rdy_i;
  assign sum_w = cnt_q + (AW+1)'(push);
  assign cnt_d = sum_w - (AW+1)'(issue);
  assign state_d = issue ? S_WAIT_BUSY :
                   (state_q == S_WAIT_BUSY && !eng_rdy_i) ? S_WAIT_DONE :
                   fin ? S_IDLE : state_q;
  assign crd = issue ? head_cmd : crd_q;
  assign {eng_x1_o, eng_y1_o, eng_x2_o, eng_y2_o} = crd;
  assign eng_start_o = issue;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign line_cnt_o = line_cnt_q;
  assign rej_cnt_o = rej_cnt_q;
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= {gnt_id, gnt_cmd};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      crd_q      <= '0;
      cur_id_q   <= '0;
      fin_q      <= 1'b0;
      done_q     <= '0;
      line_cnt_q <= '0;
      rej_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= gnt_v ? (gnt_id == IW'(NREQ - 1) ? '0 : gnt_id + 1'b1) : ptr_q;
      wp_q       <= wp_q + AW'(push);
      rp_q       <= rp_q + AW'(issue);
      cnt_q      <= cnt_d;
      crd_q      <= crd;
      cur_id_q   <= issue ? head_id : cur_id_q;
      fin_q      <= fin;
      done_q     <= (fin ? NREQ'(1) << cur_id_q : '0) | (rej ? NREQ'(1) << gnt_id : '0);
      line_cnt_q <= line_cnt_q + 16'(fin);
      rej_cnt_q  <= rej_cnt_q + 16'(rej);
      busy_q     <= cnt_d != '0 || state_d != S_IDLE;
    end
  end
endmodule

// File: tb/tb_line_cmd_sched.sv
// tb_line_cmd_sched: vector table plus hand sequences; scoreboard tracks ack -> eng_start -> done.
module tb_line_cmd_sched;
  logic clk = 1'b0, rst_n = 1'b0, eng_rdy = 1'b1, st;
  logic [3:0] req = '0, ack, done;
  logic [255:0] req_cmd = '0;
  logic eng_start, busy;
  logic [15:0] x1, y1, x2, y2, line_cnt, rej_cnt;
  int n_tests = 0, n_fail = 0, eng_len = 3, ecnt = 0;
  bit mon_en = 1'b1;
  typedef struct packed {logic [1:0] id; logic [63:0] cmd;} ent_t;
  typedef struct {logic [3:0] req; logic [3:0] ack;} vec_t;
  ent_t exp_q[$], e;
  logic [1:0] id_q[$], did;
  vec_t vt[7];

  line_cmd_sched dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_cmd_i(req_cmd), .ack_o(ack), .done_o(done),
    .eng_start_o(eng_start), .eng_x1_o(x1), .eng_y1_o(y1), .eng_x2_o(x2), .eng_y2_o(y2),
    .eng_rdy_i(eng_rdy), .busy_o(busy), .line_cnt_o(line_cnt), .rej_cnt_o(rej_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Fake engine: goes not-ready the cycle after eng_start for eng_len cycles.
  always begin
    @(negedge clk);
    st = eng_start;
    @(posedge clk);
    #1;
    if (st) begin
      eng_rdy = 1'b0;
      ecnt = eng_len;
    end else if (ecnt > 0) begin
      ecnt--;
      if (ecnt == 0) eng_rdy = 1'b1;
    end
  end

  always @(negedge clk) if (rst_n && mon_en) begin
    if (ack != 0) begin
      chk("ack_onehot", 64'($onehot(ack)), 1);
      for (int i = 0; i < 4; i++) if (ack[i]) exp_q.push_back({2'(i), req_cmd[i*64 +: 64]});
    end
    if (eng_start) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL start_unexp: got eng_start=1 want no issue");
      end else begin
        e = exp_q.pop_front();
        chk("issue_coords", {x1, y1, x2, y2}, e.cmd);
        id_q.push_back(e.id);
      end
    end
    if (done != 0) begin
      if (id_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL done_unexp: got %b want none", done);
      end else begin
        did = id_q.pop_front();
        chk("done_order", done, 4'b1 << did);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    exp_q.delete();
    id_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && eng_rdy && exp_q.size() == 0 && id_q.size() == 0) break;
    end
    chk(nm, 64'(i < 3000), 1);
  endtask

  initial begin
    int lat, k, cnt;
    bit got;
    vt[0] = '{4'b0001, 4'b0001};
    vt[1] = '{4'b0011, 4'b0010};
    vt[2] = '{4'b0101, 4'b0100};
    vt[3] = '{4'b0011, 4'b0001};
    vt[4] = '{4'b0000, 4'b0000};
    vt[5] = '{4'b1001, 4'b1000};
    vt[6] = '{4'b1111, 4'b0000};
    #3;
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_coords", {x1, y1, x2, y2}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnts", {line_cnt, rej_cnt}, 0);
    do_reset();
    // single line, minimum latency
    @(posedge clk); #1;
    req = 4'b0001;
    req_cmd[63:0] = {16'd0, 16'd0, 16'd10, 16'd5};
    @(negedge clk);
    chk("t1_ack", ack, 4'b0001);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("t1_start", eng_start, 1);
    chk("t1_coords", {x1, y1, x2, y2}, {16'd0, 16'd0, 16'd10, 16'd5});
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done != 0) begin lat = i; break; end
    end
    chk("t1_latency", lat, 5);
    chk("t1_done", done, 4'b0001);
    chk("t1_line_cnt", line_cnt, 1);
    // arbiter vector table
    do_reset();
    eng_len = 40;
    foreach (vt[v]) begin
      @(posedge clk); #1;
      req = vt[v].req;
      for (int i = 0; i < 4; i++) req_cmd[i*64 +: 64] = {$urandom, $urandom};
      @(negedge clk);
      chk($sformatf("vec%0d_ack", v), ack, vt[v].ack);
    end
    chk("vec_busy", busy, 1);
    @(posedge clk); #1;
    req = '0;
    drain("vec_drain");
    chk("vec_line_cnt", line_cnt, 5);
    // held requests rotate 0,1,2,3,...
    do_reset();
    eng_len = 20;
    for (int i = 0; i < 4; i++) req_cmd[i*64 +: 64] = {16'(i), 16'(i + 1), 16'(i + 100), 16'(i + 200)};
    @(posedge clk); #1;
    req = 4'b1111;
    k = 0;
    for (int c = 0; c < 1000 && k < 8; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        chk($sformatf("rr_ack%0d", k), ack, 4'b1 << (k % 4));
        k++;
      end
    end
    @(posedge clk); #1;
    req = '0;
    chk("rr_count", k, 8);
    drain("rr_drain");
    chk("rr_line_cnt", line_cnt, 8);
    // full FIFO: ack only the cycle after the pop
    do_reset();
    eng_len = 10;
    @(posedge clk); #1;
    req = 4'b0011;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack == 0) begin got = 1; break; end
    end
    chk("t3_full", got, 1);
    @(posedge clk); #1;
    req = 4'b0100;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (eng_start) begin
        chk("t3_no_ack_at_pop", ack[2], 0);
        @(negedge clk);
        chk("t3_ack_after_pop", ack[2], 1);
        got = 1;
        break;
      end else if (ack != 0) break;
    end
    chk("t3_seen_pop", got, 1);
    @(posedge clk); #1;
    req = '0;
    drain("t3_drain");
    // reset in S_WAIT_DONE
    @(posedge clk); #1;
    req = 4'b0100;
    req_cmd[128 +: 64] = {16'd7, 16'd8, 16'd9, 16'd10};
    @(posedge clk); #1;
    req = '0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    id_q.delete();
    #1;
    chk("t4_ack", ack, 0);
    chk("t4_done", done, 0);
    chk("t4_start", eng_start, 0);
    chk("t4_coords", {x1, y1, x2, y2}, 0);
    chk("t4_busy", busy, 0);
    chk("t4_line_cnt", line_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done != 0 || eng_start) cnt++;
    end
    chk("t4_quiet", cnt, 0);
    chk("t4_busy_after", busy, 0);
    chk("t4_line_cnt_after", line_cnt, 0);
    // line counter wrap
    eng_len = 4;
    @(posedge clk); #1;
    force dut.line_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.line_cnt_q;
    @(posedge clk); #1;
    req = 4'b1000;
    req_cmd[192 +: 64] = {16'd1, 16'd2, 16'd3, 16'd4};
    @(posedge clk); #1;
    req = '0;
    drain("t5_drain");
    chk("t5_wrap", line_cnt, 0);
`ifdef LINE_CLIP_EN
    do_reset();
    mon_en = 1'b0;
    @(posedge clk); #1;
    req = 4'b0010;
    req_cmd[64 +: 64] = {16'hFFFB, 16'd10, 16'hFFFF, 16'd20};
    @(negedge clk);
    chk("t6_rej_ack", ack, 4'b0010);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("t6_rej_nostart", eng_start, 0);
    chk("t6_rej_done", done, 4'b0010);
    chk("t6_rej_cnt", rej_cnt, 1);
    @(posedge clk); #1;
    req = 4'b0010;
    req_cmd[64 +: 64] = {16'hFFFB, 16'd10, 16'd5, 16'd20};
    @(negedge clk);
    chk("t6_ok_ack", ack, 4'b0010);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("t6_ok_start", eng_start, 1);
    chk("t6_ok_coords", {x1, y1, x2, y2}, {16'hFFFB, 16'd10, 16'd5, 16'd20});
    drain("t6_drain");
    chk("t6_cnts", {line_cnt, rej_cnt}, {16'd1, 16'd1});
    mon_en = 1'b1;
`else
    chk("rej_cnt_tied", rej_cnt, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
